// File: rtl/pr3_pkg.sv
// Shared definitions for the FFT frame scheduler.
// Holds the scheduler FSM state encoding and the default system clock rate.
package pr3_pkg;

  // Default system clock rate in Hz.
  localparam int CLKHZ_DEFAULT = 40000000;

  // Scheduler states. IDLE must stay at encoding 0 so that reset leaves
  // every state-derived output at 0.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READOUT = 2'd2
  } state_e;

endpackage

// File: rtl/fft_frame_sched_if.sv
// Sample-buffer and FFT-sink bus of the frame scheduler.
//   master (scheduler): drives buffer write/read controls and the FFT framing,
//                       receives fft_ready.
//   slave  (buffer + FFT sink side): the reverse.
// Handshake: a beat on fft_* transfers on every clock edge where fft_valid and
// fft_ready are both high. While fft_valid is high and fft_ready low the
// master holds every fft_* signal; fft_ready is meaningless while fft_valid
// is low.
interface fft_frame_sched_if #(
  parameter int NSINK = 3,
  parameter int FFT   = 11
);
  localparam int CHW = (NSINK > 1) ? $clog2(NSINK) : 1;

  logic           cap_we;
  logic [FFT-1:0] cap_addr;
  logic           rd_en;
  logic [FFT-1:0] rd_addr;
  logic [CHW-1:0] rd_ch;
  logic           fft_valid;
  logic           fft_sop;
  logic           fft_eop;
  logic [CHW-1:0] fft_ch;
  logic           fft_ready;

  modport master (
    output cap_we, cap_addr, rd_en, rd_addr, rd_ch,
    output fft_valid, fft_sop, fft_eop, fft_ch,
    input  fft_ready
  );

  modport slave (
    input  cap_we, cap_addr, rd_en, rd_addr, rd_ch,
    input  fft_valid, fft_sop, fft_eop, fft_ch,
    output fft_ready
  );
endinterface

// File: rtl/frame_tick_gen.sv
// Free-running frame trigger generator.
// Ports: clk40 (clock), reset (synchronous, active-high),
//        tick (one-cycle pulse while the count sits at PERIOD-1).
module frame_tick_gen #(
  parameter int PERIOD = 8000
) (
  input  logic clk40,
  input  logic reset,
  output logic tick
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk40) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CNT_LAST);
endmodule

// File: rtl/fft_frame_sched.sv
// FFT frame scheduler: on each frame trigger captures N samples of all NSINK
// channels in parallel into a sample buffer, then streams the buffer to one
// shared FFT core channel by channel with valid/ready backpressure.
// Ports:
//   clk40, reset      clock and synchronous active-high reset
//   enable            triggers are accepted only while high
//   bus (master)      buffer write/read controls and FFT sink framing
//   busy              frame in progress (state != IDLE)
//   frame_cnt         completed frames, wraps
//   drop_cnt          triggers lost because a frame was in progress, saturates
//   dbg_state         current FSM state
module fft_frame_sched
  import pr3_pkg::*;
#(
  parameter int NSINK = 3,
  parameter int FFT   = 11,
  parameter int FREQ  = 5000,
  parameter int CLKHZ = CLKHZ_DEFAULT
) (
  input  logic                 clk40,
  input  logic                 reset,
  input  logic                 enable,
  fft_frame_sched_if.master    bus,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          drop_cnt,
  output state_e               dbg_state
);
  localparam int N      = 2 ** FFT;
  localparam int PERIOD = CLKHZ / FREQ;
  localparam int CHW    = (NSINK > 1) ? $clog2(NSINK) : 1;
  localparam logic [FFT-1:0] ADDR_LAST = '1;
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NSINK - 1);

  // A frame must fit its capture phase inside one trigger period.
  if (PERIOD < N + 1) begin : g_period_check
    $error("fft_frame_sched: PERIOD (CLKHZ/FREQ) must be at least 2**FFT+1");
  end

  logic tick;

  frame_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk40 (clk40),
    .reset (reset),
    .tick  (tick)
  );

  state_e         state_q;
  logic           cap_we_q;
  logic [FFT-1:0] cap_addr_q;
  logic [FFT-1:0] rd_addr_q;
  logic [CHW-1:0] rd_ch_q;
  logic           rd_done_q;   // last read of the frame already issued
  logic           fft_valid_q;
  logic           fft_sop_q;
  logic           fft_eop_q;
  logic [CHW-1:0] fft_ch_q;
  logic [15:0]    frame_cnt_q;
  logic [15:0]    drop_cnt_q;

  logic rd_en_d;
  logic accept;
  logic last_accept;

  // A read may be issued when the output register is empty or being drained
  // this cycle; the buffer has one cycle of read latency, matching the
  // fft_* register stage.
  assign rd_en_d     = (state_q == ST_READOUT) && !rd_done_q &&
                       (!fft_valid_q || bus.fft_ready);
  assign accept      = fft_valid_q && bus.fft_ready;
  assign last_accept = accept && fft_eop_q && (fft_ch_q == CH_LAST);

  always_ff @(posedge clk40) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      rd_addr_q   <= '0;
      rd_ch_q     <= '0;
      rd_done_q   <= 1'b0;
      fft_valid_q <= 1'b0;
      fft_sop_q   <= 1'b0;
      fft_eop_q   <= 1'b0;
      fft_ch_q    <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (tick && (state_q != ST_IDLE) && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick && enable) begin
            state_q    <= ST_CAPTURE;
            cap_we_q   <= 1'b1;
            cap_addr_q <= '0;
          end
        end

        ST_CAPTURE: begin
          if (cap_addr_q == ADDR_LAST) begin
            state_q    <= ST_READOUT;
            cap_we_q   <= 1'b0;
            cap_addr_q <= '0;
            rd_addr_q  <= '0;
            rd_ch_q    <= '0;
            rd_done_q  <= 1'b0;
          end else begin
            cap_addr_q <= cap_addr_q + 1'b1;
          end
        end

        ST_READOUT: begin
          if (rd_en_d) begin
            fft_valid_q <= 1'b1;
            fft_ch_q    <= rd_ch_q;
            fft_sop_q   <= (rd_addr_q == '0);
            fft_eop_q   <= (rd_addr_q == ADDR_LAST);
            if (rd_addr_q == ADDR_LAST) begin
              rd_addr_q <= '0;
              if (rd_ch_q == CH_LAST) begin
                rd_ch_q   <= '0;
                rd_done_q <= 1'b1;
              end else begin
                rd_ch_q <= rd_ch_q + 1'b1;
              end
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
            end
          end else if (accept) begin
            fft_valid_q <= 1'b0;
            fft_sop_q   <= 1'b0;
            fft_eop_q   <= 1'b0;
          end

          // rd_done_q guarantees no read is issued in the same cycle.
          if (last_accept) begin
            state_q     <= ST_IDLE;
            rd_done_q   <= 1'b0;
            fft_valid_q <= 1'b0;
            fft_sop_q   <= 1'b0;
            fft_eop_q   <= 1'b0;
            fft_ch_q    <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cap_we    = cap_we_q;
  assign bus.cap_addr  = cap_addr_q;
  assign bus.rd_en     = rd_en_d;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_ch     = rd_ch_q;
  assign bus.fft_valid = fft_valid_q;
  assign bus.fft_sop   = fft_sop_q;
  assign bus.fft_eop   = fft_eop_q;
  assign bus.fft_ch    = fft_ch_q;

  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;
endmodule
